// File: rtl/rom_streamer.sv
// rom_streamer: walks a contiguous ROM region through a 1-cycle registered ROM
// and emits each word on a valid/ready byte stream.
module rom_streamer #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int LEN       = 4,
   parameter int BASE      = 0,
   parameter int TERM_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] DOUT,
   output logic [DATA_W-1:0] M_DATA,
   output logic              M_VALID,
   input  logic              M_READY
);
   if (LEN < 0 || LEN > 2**ADDR_W) begin : g_bad_len
      $error("rom_streamer: LEN must lie in 0..2**ADDR_W");
   end
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, DONE} state_t;
   localparam logic [ADDR_W:0]   L = LEN[ADDR_W:0];
   localparam logic [ADDR_W-1:0] B = BASE[ADDR_W-1:0];
   state_t            r_state, w_next;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              w_last, w_term;
   // count is one bit wider than ADDR so a full 2**ADDR_W walk terminates
   assign w_last  = r_count + 1'b1 == L;
   assign w_term  = TERM_ZERO != 0 && DOUT == '0;
   assign busy    = r_state != IDLE;
   assign done    = r_state == DONE;
   assign M_VALID = r_state == SEND;
   assign ADDR    = r_addr;
   assign M_DATA  = r_data;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? (L == '0 ? DONE : FETCH) : IDLE;
         FETCH:   w_next = LATCH;
         LATCH:   w_next = w_term ? DONE : SEND;
         SEND:    w_next = M_READY ? (w_last ? DONE : FETCH) : SEND;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= B;
         r_count <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next == FETCH) begin
            r_addr  <= B;
            r_count <= '0;
         end
         if (r_state == LATCH && !w_term) r_data <= DOUT;
         if (r_state == SEND && M_READY) begin
            r_count <= r_count + 1'b1;
            if (!w_last) r_addr <= r_addr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: five differently parameterised streamers over one shared ROM image,
// directed vector table, stall/reset/re-start corners, then random ROM and back-pressure.
module tb_rom_streamer;
   localparam int N = 5;
   logic       clk = 0, rst;
   logic       st[N], bsy[N], dn[N], vld[N], rdy[N];
   logic [3:0] addr[N];
   logic [7:0] dout[N], mdata[N];
   logic [7:0] mem[16];
   int         passed = 0, total = 0;
   int         got_first, got_gap, bad, post;
   logic [7:0] got_d[$], exp_d[$];
   logic [3:0] got_a[$], exp_a[$];

   always #5 clk = ~clk;

   function automatic int pl(int k); return k == 0 ? 4 : k == 1 ? 8 : k == 2 ? 6 : k == 3 ? 4 : 0; endfunction
   function automatic int pb(int k); return k == 3 ? 14 : 0; endfunction
   function automatic int pt(int k); return (k == 2 || k == 3) ? 0 : 1; endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      rom_streamer #(.ADDR_W(4), .DATA_W(8), .LEN(pl(g)), .BASE(pb(g)), .TERM_ZERO(pt(g))) u_dut (
         .clk(clk), .rst(rst), .start(st[g]), .busy(bsy[g]), .done(dn[g]), .ADDR(addr[g]),
         .DOUT(dout[g]), .M_DATA(mdata[g]), .M_VALID(vld[g]), .M_READY(rdy[g]));
      always @(posedge clk) dout[g] <= mem[addr[g]];
   end

   function automatic void chk(string nm, int got, int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
   endfunction

   // drives one transfer from a negedge; records handshakes, first-valid and done timing
   task automatic run(input int k, input int stall_at, input bit rep, input bit rnd);
      int         cyc = 0, last_hs = 0, stall = 0;
      bit         hold = 0;
      logic [7:0] pd = 0;
      logic [3:0] pa = 0;
      got_d.delete(); got_a.delete();
      got_first = -1; got_gap = -1; bad = 0;
      st[k] = 1;
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         st[k] = rep && cyc % 4 == 2;
         if (hold && (!vld[k] || mdata[k] != pd || addr[k] != pa)) bad = 1;
         if (dn[k] && vld[k]) bad = 1;
         if (vld[k] && got_first < 0) got_first = cyc;
         if (dn[k]) begin
            got_gap = cyc - last_hs;
            st[k] = rep;
            break;
         end
         if (rnd) rdy[k] = $urandom_range(0, 2) != 0;
         else if (vld[k] && got_d.size() == stall_at && stall < 5) begin
            rdy[k] = 0;
            stall++;
         end else rdy[k] = 1;
         if (vld[k] && rdy[k]) begin
            got_d.push_back(mdata[k]);
            got_a.push_back(addr[k]);
            last_hs = cyc;
         end
         hold = vld[k] && !rdy[k];
         pd = mdata[k];
         pa = addr[k];
      end
      rdy[k] = 0;
      @(negedge clk);
      st[k] = 0;
      post = {bsy[k], dn[k], vld[k]};
   endtask

   typedef struct {
      int k; int stall_at; bit rep; int n;
      logic [7:0] d[6]; logic [3:0] a[6]; int gap; int first;
   } vec_t;
   vec_t tbl[7];

   initial begin
      rst = 1;
      for (int k = 0; k < N; k++) begin st[k] = 0; rdy[k] = 0; end
      for (int a = 0; a < 16; a++) mem[a] = 0;
      mem[0] = 70; mem[1] = 80; mem[2] = 71; mem[3] = 65; mem[14] = 1; mem[15] = 2;
      tbl[0] = '{0, -1, 0, 4, '{70, 80, 71, 65, 0, 0}, '{0, 1, 2, 3, 0, 0}, 1, 3};
      tbl[1] = '{0,  1, 0, 4, '{70, 80, 71, 65, 0, 0}, '{0, 1, 2, 3, 0, 0}, 1, 3};
      tbl[2] = '{1, -1, 0, 4, '{70, 80, 71, 65, 0, 0}, '{0, 1, 2, 3, 0, 0}, 3, 3};
      tbl[3] = '{2, -1, 0, 6, '{70, 80, 71, 65, 0, 0}, '{0, 1, 2, 3, 4, 5}, 1, 3};
      tbl[4] = '{3, -1, 0, 4, '{1, 2, 70, 80, 0, 0},   '{14, 15, 0, 1, 0, 0}, 1, 3};
      tbl[5] = '{0, -1, 1, 4, '{70, 80, 71, 65, 0, 0}, '{0, 1, 2, 3, 0, 0}, 1, 3};
      tbl[6] = '{4, -1, 0, 0, '{0, 0, 0, 0, 0, 0},     '{0, 0, 0, 0, 0, 0}, 1, -1};
      repeat (2) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("reset_busy%0d", k), bsy[k], 0);
         chk($sformatf("reset_done%0d", k), dn[k], 0);
         chk($sformatf("reset_valid%0d", k), vld[k], 0);
         chk($sformatf("reset_data%0d", k), mdata[k], 0);
         chk($sformatf("reset_addr%0d", k), addr[k], pb(k));
      end
      rst = 0;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         run(tbl[i].k, tbl[i].stall_at, tbl[i].rep, 0);
         chk($sformatf("t%0d_count", i), got_d.size(), tbl[i].n);
         for (int j = 0; j < tbl[i].n && j < got_d.size(); j++) begin
            chk($sformatf("t%0d_data%0d", i, j), got_d[j], tbl[i].d[j]);
            chk($sformatf("t%0d_addr%0d", i, j), got_a[j], tbl[i].a[j]);
         end
         chk($sformatf("t%0d_done_gap", i), got_gap, tbl[i].gap);
         chk($sformatf("t%0d_first_valid", i), got_first, tbl[i].first);
         chk($sformatf("t%0d_stable_excl", i), bad, 0);
         chk($sformatf("t%0d_idle_after", i), post, 0);
      end
      begin
         int w = 0, nd = 0;
         st[0] = 1;
         @(negedge clk);
         st[0] = 0;
         while (!vld[0] && w < 10) begin @(negedge clk); w++; end
         chk("rst_reach_valid", vld[0], 1);
         rst = 1;
         @(negedge clk);
         rst = 0;
         chk("rst_valid", vld[0], 0);
         chk("rst_busy", bsy[0], 0);
         chk("rst_done", dn[0], 0);
         repeat (4) begin @(negedge clk); nd |= dn[0]; end
         chk("rst_no_done", nd, 0);
         run(0, -1, 0, 0);
         chk("rst_restart_count", got_d.size(), 4);
         chk("rst_restart_first", got_d.size() > 0 ? int'(got_d[0]) : -1, 70);
      end
      for (int r = 0; r < 12; r++) begin
         int k = $urandom_range(0, N - 1);
         for (int a = 0; a < 16; a++) mem[a] = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom_range(1, 255));
         exp_d.delete(); exp_a.delete();
         for (int j = 0; j < pl(k); j++) begin
            logic [3:0] a = 4'(pb(k) + j);
            if (pt(k) != 0 && mem[a] == 0) break;
            exp_d.push_back(mem[a]);
            exp_a.push_back(a);
         end
         run(k, -1, 0, 1);
         chk($sformatf("r%0d_k%0d_count", r, k), got_d.size(), exp_d.size());
         for (int j = 0; j < exp_d.size() && j < got_d.size(); j++) begin
            chk($sformatf("r%0d_data%0d", r, j), got_d[j], exp_d[j]);
            chk($sformatf("r%0d_addr%0d", r, j), got_a[j], exp_a[j]);
         end
         chk($sformatf("r%0d_done_seen", r), got_gap >= 0, 1);
         chk($sformatf("r%0d_stable_excl", r), bad, 0);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
